// File: rtl/m68k_mem_bridge_if.sv
// Bus bundle between the 68000 core, the SDRAM controller and the I/O port.
// The master modport is the bridge's view; slave is the view of the
// surrounding CPU, controller and I/O logic.
interface m68k_mem_bridge_if;
    // CPU side
    logic [22:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_asn;
    logic        cpu_udsn;
    logic        cpu_ldsn;
    logic        cpu_rw;
    logic        cpu_dtackn;
    logic        cpu_berrn;

    // SDRAM controller side
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_asn;
    logic        mem_udsn;
    logic        mem_ldsn;
    logic        mem_rw;

    // I/O port side
    logic        io_sel;
    logic        io_ack;
    logic [15:0] io_rdata;

    modport master (
        input  cpu_addr, cpu_din, cpu_asn, cpu_udsn, cpu_ldsn, cpu_rw,
        input  mem_dout, io_ack, io_rdata,
        output cpu_dout, cpu_dtackn, cpu_berrn,
        output mem_addr, mem_din, mem_asn, mem_udsn, mem_ldsn, mem_rw,
        output io_sel
    );

    modport slave (
        output cpu_addr, cpu_din, cpu_asn, cpu_udsn, cpu_ldsn, cpu_rw,
        output mem_dout, io_ack, io_rdata,
        input  cpu_dout, cpu_dtackn, cpu_berrn,
        input  mem_addr, mem_din, mem_asn, mem_udsn, mem_ldsn, mem_rw,
        input  io_sel
    );
endinterface

// File: rtl/m68k_mem_bridge.sv
// 68000 bus to SDRAM controller / I/O port bridge.
// SDRAM cycles run for a fixed worst-case latency so a refresh already in
// flight is always covered; I/O cycles wait for io_ack or time out with BERR.
module m68k_mem_bridge #(
    parameter logic [23:0] RAM_TOP    = 24'h400000,
    parameter int unsigned MEM_LAT    = 16,
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic              clk_in,
    input  logic              rst_n,
    m68k_mem_bridge_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_MEM,
        ST_IO,
        ST_ACK,
        ST_END
    } state_t;

    localparam logic [7:0] LAT_LOAD = 8'(MEM_LAT - 1);
    localparam logic [7:0] IO_LIMIT = 8'(IO_TIMEOUT);

    state_t     state;
    logic [7:0] lat_cnt;
    logic [7:0] io_cnt;
    logic       lat_rw;
    logic       is_ram;

    // Address decode of the live CPU address; only consulted in START.
    always_comb begin
        is_ram = ({1'b0, bus.cpu_addr} < RAM_TOP);
    end

    // Bus cycle sequencer with registered CPU, controller and I/O outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            lat_cnt        <= '0;
            io_cnt         <= '0;
            lat_rw         <= 1'b1;
            bus.cpu_dout   <= '0;
            bus.cpu_dtackn <= 1'b1;
            bus.cpu_berrn  <= 1'b1;
            bus.mem_addr   <= '0;
            bus.mem_din    <= '0;
            bus.mem_asn    <= 1'b1;
            bus.mem_udsn   <= 1'b1;
            bus.mem_ldsn   <= 1'b1;
            bus.mem_rw     <= 1'b1;
            bus.io_sel     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.cpu_asn) begin
                        if (bus.cpu_udsn && bus.cpu_ldsn) begin
                            // Early write phase: hold off controller refresh
                            // while the CPU has not yet presented data.
                            bus.mem_asn  <= 1'b0;
                            bus.mem_udsn <= 1'b1;
                            bus.mem_ldsn <= 1'b1;
                        end else begin
                            state <= ST_START;
                        end
                    end else begin
                        bus.mem_asn <= 1'b1;
                    end
                end

                ST_START: begin
                    lat_rw <= bus.cpu_rw;
                    if (is_ram) begin
                        bus.mem_addr <= {1'b0, bus.cpu_addr};
                        bus.mem_din  <= bus.cpu_din;
                        bus.mem_udsn <= bus.cpu_udsn;
                        bus.mem_ldsn <= bus.cpu_ldsn;
                        bus.mem_rw   <= bus.cpu_rw;
                        bus.mem_asn  <= 1'b0;
                        lat_cnt      <= LAT_LOAD;
                        state        <= ST_MEM;
                    end else begin
                        bus.mem_asn  <= 1'b1;
                        bus.io_sel   <= 1'b1;
                        io_cnt       <= '0;
                        state        <= ST_IO;
                    end
                end

                ST_MEM: begin
                    // The count always runs to completion, even if the CPU
                    // has dropped AS, so the controller never loses strobes
                    // mid-access; only DTACK is suppressed.
                    if (lat_cnt == '0) begin
                        if (lat_rw) begin
                            bus.cpu_dout <= bus.mem_dout;
                        end
                        if (!bus.cpu_asn) begin
                            bus.cpu_dtackn <= 1'b0;
                            state          <= ST_ACK;
                        end else begin
                            state          <= ST_END;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end

                ST_IO: begin
                    // Acknowledge takes priority over a timeout on the same clock.
                    if (bus.io_ack) begin
                        if (lat_rw) begin
                            bus.cpu_dout <= bus.io_rdata;
                        end
                        bus.cpu_dtackn <= 1'b0;
                        state          <= ST_ACK;
                    end else if (io_cnt == IO_LIMIT) begin
                        bus.cpu_berrn  <= 1'b0;
                        state          <= ST_ACK;
                    end else if (bus.cpu_asn) begin
                        state          <= ST_END;
                    end else begin
                        io_cnt <= io_cnt + 8'd1;
                    end
                end

                ST_ACK: begin
                    if (bus.cpu_asn) begin
                        state <= ST_END;
                    end
                end

                ST_END: begin
                    bus.cpu_dtackn <= 1'b1;
                    bus.cpu_berrn  <= 1'b1;
                    bus.mem_asn    <= 1'b1;
                    bus.mem_udsn   <= 1'b1;
                    bus.mem_ldsn   <= 1'b1;
                    bus.mem_rw     <= 1'b1;
                    bus.io_sel     <= 1'b0;
                    state          <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_mem_bridge.sv
// Self-checking bench for m68k_mem_bridge: directed test-plan cycles followed
// by randomized SDRAM/I/O cycles checked edge by edge against a timing model
// derived from the cycle rules (completion edge, release edge, abort).
module tb_m68k_mem_bridge;

    localparam logic [23:0] RAM_TOP    = 24'h400000;
    localparam int          MEM_LAT    = 16;
    localparam int          IO_TIMEOUT = 255;
    // Edge offsets from E (IDLE first samples a data strobe low).
    localparam int          D_EDGE     = 1 + MEM_LAT;     // SDRAM capture / DTACK
    localparam int          T_EDGE     = IO_TIMEOUT + 2;  // BERR

    logic clk_in = 1'b0;
    logic rst_n;

    m68k_mem_bridge_if bus ();

    m68k_mem_bridge #(
        .RAM_TOP   (RAM_TOP),
        .MEM_LAT   (MEM_LAT),
        .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] exp_dout = '0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkb(input string tag, input logic got, input logic want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, want);
        end
    endtask

    task automatic checkw(input string tag, input logic [23:0] got, input logic [23:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checkb({tag, "_dtackn"}, bus.cpu_dtackn, 1'b1);
        checkb({tag, "_berrn"},  bus.cpu_berrn,  1'b1);
        checkb({tag, "_mem_asn"}, bus.mem_asn,   1'b1);
        checkb({tag, "_mem_udsn"}, bus.mem_udsn, 1'b1);
        checkb({tag, "_mem_ldsn"}, bus.mem_ldsn, 1'b1);
        checkb({tag, "_mem_rw"}, bus.mem_rw,     1'b1);
        checkb({tag, "_io_sel"}, bus.io_sel,     1'b0);
        checkw({tag, "_cpu_dout"}, 24'(bus.cpu_dout), 24'(exp_dout));
    endtask

    // One complete CPU bus cycle.
    // abort_a: 0 = CPU holds AS until after completion, >0 = edge (from E) at
    // which AS=1 is first sampled, -1 = random abort point.
    // ack_dly: clocks after io_sel rises before io_ack is sampled, -1 = none.
    task automatic do_cycle(input logic [22:0] addr, input logic [15:0] din,
                            input logic rw, input logic uds_n, input logic lds_n,
                            input int early, input int abort_a, input int ack_dly,
                            input logic [15:0] rdata);
        logic ram;
        logic to_case;
        logic ab;
        logic want_dt, want_be, want_ma, want_sel;
        int   kk, cc, aa, ff;

        cyc++;
        ram     = ({1'b0, addr} < RAM_TOP);
        kk      = (ack_dly >= 0) ? 2 + ack_dly : -1;
        to_case = !ram && !(kk >= 0 && kk <= T_EDGE);
        cc      = ram ? D_EDGE : (to_case ? T_EDGE : kk);

        ab = 1'b0;
        aa = cc + 1 + int'($urandom_range(3, 0));
        if (abort_a > 0) begin
            aa = abort_a;
            ab = (aa <= cc) && (ram || aa < cc);
        end else if (abort_a < 0) begin
            if (ram) begin
                aa = int'($urandom_range(D_EDGE, 2));
                ab = 1'b1;
            end else if (cc >= 3) begin
                aa = int'($urandom_range(cc - 1, 2));
                ab = 1'b1;
            end
        end
        ff = ram ? ((aa > D_EDGE) ? aa : D_EDGE) : aa;

        bus.cpu_addr = addr;
        bus.cpu_din  = din;
        bus.cpu_rw   = rw;
        bus.cpu_asn  = 1'b0;
        bus.cpu_udsn = 1'b1;
        bus.cpu_ldsn = 1'b1;
        bus.io_ack   = 1'b0;
        bus.mem_dout = ram ? rdata : 16'($urandom);
        bus.io_rdata = ram ? 16'($urandom) : rdata;

        for (int i = 0; i < early; i++) begin
            step();
            checkb("early_mem_asn",  bus.mem_asn,    1'b0);
            checkb("early_mem_udsn", bus.mem_udsn,   1'b1);
            checkb("early_mem_ldsn", bus.mem_ldsn,   1'b1);
            checkb("early_dtackn",   bus.cpu_dtackn, 1'b1);
        end

        bus.cpu_udsn = uds_n;
        bus.cpu_ldsn = lds_n;
        step();  // edge E
        checkb("e0_mem_asn", bus.mem_asn, (early > 0) ? 1'b0 : 1'b1);
        checkb("e0_dtackn",  bus.cpu_dtackn, 1'b1);

        for (int k = 1; k <= ff + 1; k++) begin
            bus.cpu_asn = (k >= aa);
            bus.io_ack  = (k == kk);
            if (k >= aa) begin
                bus.cpu_udsn = 1'b1;
                bus.cpu_ldsn = 1'b1;
            end else if (k >= 2) begin
                // Inputs after START must not disturb the latched cycle.
                bus.cpu_udsn = 1'($urandom);
                bus.cpu_ldsn = 1'($urandom);
                bus.cpu_rw   = 1'($urandom);
                bus.cpu_din  = 16'($urandom);
                bus.cpu_addr = 23'($urandom);
            end
            step();

            if (k == cc && rw && (ram || (!to_case && !ab))) begin
                exp_dout = rdata;
            end
            want_dt  = (!ab && !to_case && k >= cc && k <= ff) ? 1'b0 : 1'b1;
            want_be  = (!ab &&  to_case && k >= cc && k <= ff) ? 1'b0 : 1'b1;
            want_ma  = (ram && k <= ff) ? 1'b0 : 1'b1;
            want_sel = (!ram && k <= ff);

            checkb("dtackn",   bus.cpu_dtackn, want_dt);
            checkb("berrn",    bus.cpu_berrn,  want_be);
            checkb("mem_asn",  bus.mem_asn,    want_ma);
            checkb("io_sel",   bus.io_sel,     want_sel);
            checkw("cpu_dout", 24'(bus.cpu_dout), 24'(exp_dout));

            if (ram && (k == 2 || k == ff)) begin
                checkw("mem_addr", bus.mem_addr, {1'b0, addr});
                checkw("mem_din",  24'(bus.mem_din), 24'(din));
                checkb("mem_udsn", bus.mem_udsn, uds_n);
                checkb("mem_ldsn", bus.mem_ldsn, lds_n);
                checkb("mem_rw",   bus.mem_rw,   rw);
            end
            if (k == ff + 1) begin
                checkb("end_mem_udsn", bus.mem_udsn, 1'b1);
                checkb("end_mem_ldsn", bus.mem_ldsn, 1'b1);
                checkb("end_mem_rw",   bus.mem_rw,   1'b1);
            end
        end
        bus.io_ack = 1'b0;
    endtask

    initial begin
        logic        r_ram, r_rw, r_uds, r_lds;
        logic [22:0] r_addr;
        int          r_early, r_abort, r_ack;

        // Reset state
        rst_n        = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din  = '0;
        bus.cpu_asn  = 1'b1;
        bus.cpu_udsn = 1'b1;
        bus.cpu_ldsn = 1'b1;
        bus.cpu_rw   = 1'b1;
        bus.mem_dout = '0;
        bus.io_ack   = 1'b0;
        bus.io_rdata = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        checkw("reset_mem_addr", bus.mem_addr, 24'h0);
        checkw("reset_mem_din",  24'(bus.mem_din), 24'h0);
        rst_n = 1'b1;
        step();

        // SDRAM read
        do_cycle(23'h001234, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, -1, 16'hBEEF);
        step();

        // Reset held for 3 clocks in the middle of an SDRAM access
        cyc++;
        bus.cpu_addr = 23'h000100;
        bus.cpu_rw   = 1'b1;
        bus.cpu_asn  = 1'b0;
        bus.cpu_udsn = 1'b0;
        bus.cpu_ldsn = 1'b0;
        bus.mem_dout = 16'h1111;
        repeat (6) step();
        checkb("pre_reset_mem_asn", bus.mem_asn, 1'b0);
        rst_n = 1'b0;
        step();
        exp_dout = '0;
        check_idle_outputs("midreset");
        checkw("midreset_mem_addr", bus.mem_addr, 24'h0);
        repeat (2) step();
        rst_n        = 1'b1;
        bus.cpu_asn  = 1'b1;
        bus.cpu_udsn = 1'b1;
        bus.cpu_ldsn = 1'b1;
        for (int i = 0; i < MEM_LAT + 2; i++) begin
            step();
            checkb("post_reset_dtackn", bus.cpu_dtackn, 1'b1);
            checkb("post_reset_mem_asn", bus.mem_asn, 1'b1);
        end

        // SDRAM upper-byte write with early write phase
        do_cycle(23'h000ABC, 16'hA500, 1'b0, 1'b0, 1'b1, 2, 0, -1, 16'h0000);
        // I/O read at exactly RAM_TOP, acknowledged 5 clocks after io_sel
        do_cycle(23'h400000, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 5, 16'h0042);
        // SDRAM read at RAM_TOP-1
        do_cycle(23'h3FFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, -1, 16'h5A5A);
        // I/O timeout
        do_cycle(23'h7FFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, -1, 16'h9999);
        // io_ack on the same clock as the timeout
        do_cycle(23'h412345, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 0, T_EDGE - 2, 16'h7E7E);
        // CPU abort during MEM
        do_cycle(23'h000777, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 6, -1, 16'hC0DE);
        // I/O write with early phase, acked immediately
        do_cycle(23'h500000, 16'h1234, 1'b0, 1'b0, 1'b0, 1, 0, 0, 16'hFFFF);
        step();
        check_idle_outputs("directed_end");

        // Randomized cycles
        for (int n = 0; n < 40; n++) begin
            r_ram   = ($urandom_range(9, 0) < 6);
            r_addr  = r_ram ? {1'b0, 22'($urandom)} : {1'b1, 22'($urandom)};
            if ($urandom_range(9, 0) == 0) begin
                r_addr = r_ram ? 23'h3FFFFF : 23'h400000;
            end
            r_rw    = 1'($urandom);
            r_uds   = 1'($urandom);
            r_lds   = r_uds ? 1'b0 : 1'($urandom);
            r_early = r_rw ? 0 : int'($urandom_range(3, 0));
            r_abort = ($urandom_range(4, 0) == 0) ? -1 : 0;
            r_ack   = ($urandom_range(11, 0) == 0) ? -1 : int'($urandom_range(12, 0));
            do_cycle(r_addr, 16'($urandom), r_rw, r_uds, r_lds, r_early,
                     r_abort, r_ack, 16'($urandom));
            repeat ($urandom_range(2, 0)) step();
        end
        step();
        check_idle_outputs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
